// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM peripheral.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: counter width, full-duty code, channel count, channel config
// struct and the per-channel output select function.
package pwm_pkg;

  localparam int unsigned           PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0]  DUTY_FULL = 8'hFF;
  localparam logic [PWM_CNT_W-1:0]  CNT_MAX   = 8'hFF;
  localparam int unsigned           NUM_CH    = 16;
  localparam int unsigned           PRESC_W   = 16;

  // Channel configuration, bit i = channel i (0-7 uo_out, 8-15 uio_out).
  typedef struct packed {
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
  } ch_cfg_t;

  // Channel value: off when disabled, constant high when enabled without
  // PWM, otherwise follows the shared PWM level.
  function automatic logic [NUM_CH-1:0] ch_select(input ch_cfg_t cfg,
                                                  input logic    level);
    return cfg.en_out & (~cfg.en_pwm | {NUM_CH{level}});
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: divides clk down to one tick every PRESCALE cycles.
// Latency: tick is combinational from the count register (high at PRESCALE-1).
// Backpressure: none; free-running.
//
// Ports: clk (clock), rst (async active-high reset),
//        tick (one-clk strobe every PRESCALE clk cycles).
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 13
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] presc_cnt;

  // With PRESCALE=1, LAST is 0: the counter holds at 0 and tick is
  // permanently high, i.e. one tick per clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (presc_cnt == LAST) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  assign tick = (presc_cnt == LAST);

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel output peripheral: each channel off, constant on, or shared PWM.
// Latency: outputs and period_start registered, 1 clk after any input/counter change.
// Backpressure: none; free-running, no flow control.
//
// Ports: clk, rst (async active-high); en_reg_out_* output enables and
//        en_reg_pwm_* PWM selects (bits 7:0 -> uo_out, 15:8 -> uio_out);
//        pwm_duty_cycle (high ticks per 256-tick period); uo_out, uio_out
//        channel outputs; period_start one-clk pulse at each period start.
// Build option: define PWM_DUTY_SHADOW_EN to latch the duty only at period
//        boundaries; otherwise duty changes apply immediately.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic       period_start
);

  logic                 tick;
  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic [PWM_CNT_W-1:0] duty_active;
  logic                 period_end;
  logic                 pwm_level;
  ch_cfg_t              ch_cfg;
  logic [NUM_CH-1:0]    ch_nxt;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Tick counter; wraps 255 -> 0 naturally at the period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Last clk of the period: the tick that takes pwm_cnt from 255 to 0.
  assign period_end = tick && (pwm_cnt == CNT_MAX);

`ifdef PWM_DUTY_SHADOW_EN
  // Shadowed duty: the whole period runs with one duty value, avoiding
  // glitchy partial periods when software rewrites the duty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_active <= '0;
    end else if (period_end) begin
      duty_active <= pwm_duty_cycle;
    end
  end
`else
  assign duty_active = pwm_duty_cycle;
`endif

  // Full-scale duty is forced high so 0xFF gives 100% rather than 255/256.
  assign pwm_level = (duty_active == DUTY_FULL) ? 1'b1 : (pwm_cnt < duty_active);

  assign ch_cfg.en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign ch_cfg.en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign ch_nxt        = ch_select(ch_cfg, pwm_level);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uo_out       <= '0;
      uio_out      <= '0;
      period_start <= 1'b0;
    end else begin
      uo_out       <= ch_nxt[7:0];
      uio_out      <= ch_nxt[15:8];
      period_start <= period_end;
    end
  end

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 Parameter PRESCALE, default 13, SHALL set clk cycles per PWM tick; legal range 1..65535.
REQ-002 clk  input  1  SHALL be the single clock; all state on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 en_reg_out_7_0  input  8  SHALL be the output enables for uo_out[7:0].
REQ-005 en_reg_out_15_8  input  8  SHALL be the output enables for uio_out[7:0].
REQ-006 en_reg_pwm_7_0  input  8  SHALL be the PWM-mode selects for uo_out[7:0].
REQ-007 en_reg_pwm_15_8  input  8  SHALL be the PWM-mode selects for uio_out[7:0].
REQ-008 pwm_duty_cycle  input  8  SHALL be the requested duty in ticks per 256-tick period.
REQ-009 uo_out  output  8  SHALL be registered output channels 0-7.
REQ-010 uio_out  output  8  SHALL be registered output channels 8-15.
REQ-011 period_start  output  1  SHALL be a one-clk pulse marking the first tick of each PWM period.

Function
REQ-012 The prescaler SHALL count 0..PRESCALE-1, assert tick at PRESCALE-1, then wrap to 0; PRESCALE=1 SHALL tick every clk.
REQ-013 The 8-bit pwm_cnt SHALL increment on tick and wrap 255->0, giving a period of 256*PRESCALE clk.
REQ-014 The period boundary SHALL be the clk where tick is high and pwm_cnt==255; period_start SHALL be registered from it, high for exactly one clk.
REQ-015 pwm_level SHALL be 1 when duty_active==8'hFF, else (pwm_cnt < duty_active); duty 0 SHALL give constant low.
REQ-016 Channel i SHALL be 0 if its out-enable is 0; 1 if enabled and its PWM select is 0; pwm_level if both are 1.
REQ-017 Outputs SHALL be registered, with one clk latency from any input or counter change.
REQ-018 Enable and PWM-select inputs SHALL take effect within one clk, without waiting for a period boundary.
REQ-019 A PWM select with its out-enable at 0 SHALL have no effect on the output.

Reset
REQ-020 rst high SHALL immediately clear the prescaler, pwm_cnt, duty_active, uo_out, uio_out and period_start to 0.
REQ-021 Reset asserted mid-period SHALL abort the period; after release, counting SHALL restart from 0 on the next clk.

Configuration
REQ-022 Macro PWM_DUTY_SHADOW_EN defined: duty_active SHALL be a register loaded from pwm_duty_cycle only at the period boundary (REQ-014).
REQ-023 PWM_DUTY_SHADOW_EN undefined: duty_active SHALL equal pwm_duty_cycle combinationally, so duty changes apply mid-period.

Structure
REQ-024 Package pwm_pkg SHALL hold PWM_CNT_W=8, DUTY_FULL=8'hFF and the channel count 16.
REQ-025 The prescaler SHALL be a sub-module pwm_prescaler (ports clk, rst, tick) that instantiates PRESCALE.

Verification (PRESCALE=13, period 3328 clk)
REQ-026 Assert rst mid-run -> all outputs and period_start 0 in the same clk; first period_start 3328 clk after release.
REQ-027 en_reg_out_7_0=0x01, en_reg_pwm_7_0=0x00 -> uo_out=0x01 one clk later; en_reg_out_7_0=0x00 -> uo_out=0x00 one clk later.
REQ-028 en_reg_out_7_0=0x01, en_reg_pwm_7_0=0x01, duty=0x80 -> uo_out[0] high 1664 clk, low 1664 clk, repeating.
REQ-029 duty=0x00 -> PWM channel always low; duty=0xFF -> always high; with en_reg_out_15_8=0xFF, en_reg_pwm_15_8=0x00 -> uio_out=0xFF.
REQ-030 PWM_DUTY_SHADOW_EN: duty changed 0x40->0xC0 mid-period -> 832 clk high in the current period, 2496 clk high from the next period_start.
REQ-031 Without PWM_DUTY_SHADOW_EN, same change at pwm_cnt=0x50 -> uo_out[0] returns high one clk later.
